// File: rtl/trace_pkg.sv
// Shared types for the commit trace monitor: record layout and serializer states.
package trace_pkg;

  localparam logic TR_GRF = 1'b0;
  localparam logic TR_DM  = 1'b1;

  // One architectural write: 1 + 32 + 32 + 32 = 97 bits.
  typedef struct packed {
    logic        rtype;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  typedef enum logic [1:0] {
    S_PC   = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } ser_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Dual-push, single-pop show-ahead FIFO of trace records.
// Port A has priority for free space; free space is measured before any pop
// in the same cycle, so a simultaneous pop never makes room for a push.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_a,
  input  trace_rec_t data_a,
  input  logic       push_b,
  input  trace_rec_t data_b,
  output logic       accept_a,
  output logic       accept_b,
  input  logic       pop,
  output trace_rec_t head,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t    mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [AW:0]   count;
  logic [AW:0]   free;
  logic [AW:0]   wr_b_ptr;

  assign count    = wr_ptr_reg - rd_ptr_reg;
  assign free     = (AW + 1)'(DEPTH) - count;
  assign accept_a = push_a && (free != '0);
  // B needs one slot beyond whatever A just took.
  assign accept_b = push_b && (free > {{AW{1'b0}}, accept_a});
  assign wr_b_ptr = accept_a ? wr_ptr_reg + (AW + 1)'(1) : wr_ptr_reg;
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign head     = mem[rd_ptr_reg[AW-1:0]];

  // Record storage; B lands directly behind A when both are accepted.
  always_ff @(posedge clk) begin
    if (accept_a) mem[wr_ptr_reg[AW-1:0]] <= data_a;
    if (accept_b) mem[wr_b_ptr[AW-1:0]]   <= data_b;
  end

  // Pointer update; the extra MSB separates full from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, accept_a} + {{AW{1'b0}}, accept_b};
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/commit_trace_monitor.sv
// Captures GRF and DM commits, buffers them and streams each record out as
// three 32-bit words (pc, {type, addr[30:0]}, data) over ready/valid.
module commit_trace_monitor
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grf_we,
  input  logic [31:0]       grf_pc,
  input  logic [4:0]        grf_addr,
  input  logic [31:0]       grf_wdata,
  input  logic              dm_we,
  input  logic [31:0]       dm_pc,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  trace_rec_t   grf_rec;
  trace_rec_t   dm_rec;
  trace_rec_t   head;
  logic         grf_event;
  logic         grf_accept;
  logic         dm_accept;
  logic         fifo_empty;
  logic         handshake;
  logic         pop;
  logic [1:0]   drops;
  logic [DROP_W:0] drop_sum;
  ser_state_t   state_reg;
  logic         overflow_reg;
  logic [DROP_W-1:0] drop_reg;

  // Writes to $0 have no architectural effect, so they are never traced.
  assign grf_event = grf_we && (grf_addr != 5'd0);
  assign grf_rec   = '{rtype: TR_GRF, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_wdata};
  assign dm_rec    = '{rtype: TR_DM, pc: dm_pc, addr: dm_addr, data: dm_wdata};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_a   (grf_event),
    .data_a   (grf_rec),
    .push_b   (dm_we),
    .data_b   (dm_rec),
    .accept_a (grf_accept),
    .accept_b (dm_accept),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign handshake = out_valid && out_ready;
  assign pop       = handshake && (state_reg == S_DATA);
  assign out_last  = out_valid && (state_reg == S_DATA);

  // Word select; forced to zero when idle so reset yields out_data = 0 at once.
  always_comb begin
    out_data = 32'd0;
    if (out_valid) begin
      case (state_reg)
        S_PC:    out_data = head.pc;
        S_HDR:   out_data = {head.rtype, head.addr[30:0]};
        S_DATA:  out_data = head.data;
        default: out_data = 32'd0;
      endcase
    end
  end

  // Serializer: step through the three words of the head record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_PC;
    end else if (handshake) begin
      case (state_reg)
        S_PC:    state_reg <= S_HDR;
        S_HDR:   state_reg <= S_DATA;
        default: state_reg <= S_PC;
      endcase
    end
  end

  assign drops    = {1'b0, grf_event && !grf_accept} + {1'b0, dm_we && !dm_accept};
  assign drop_sum = {1'b0, drop_reg} + (DROP_W + 1)'(drops);

  // Drop accounting: saturating counter plus sticky flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      drop_reg     <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      overflow_reg <= overflow_reg || (drops != 2'd0);
    end
  end

  assign drop_count = drop_reg;
  assign overflow   = overflow_reg;

endmodule

// File: doc/commit_trace_monitor.md
# commit_trace_monitor

Synthesizable observer on the CPU's architectural write ports: it captures every register-file (GRF) write and data-memory (DM) write, buffers them, and streams them out as 32-bit words over a ready/valid interface. It is the receiving end of the stimulus the CPU bench applies: the bench drives `clk`/`reset` into `mips`, and this block carries the resulting commit trace back out to a checker or host, in place of simulation-only `$display` traces.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in records; power of two, ≥ 2.
- `DROP_W`, 16: width of the drop counter.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `grf_we`  in  1  GRF write strobe this cycle.
- `grf_pc`  in  32  PC of the writing instruction.
- `grf_addr`  in  5  destination register.
- `grf_wdata`  in  32  value written.
- `dm_we`  in  1  DM write strobe this cycle.
- `dm_pc`  in  32  PC of the storing instruction.
- `dm_addr`  in  32  byte address; bit 31 is always 0.
- `dm_wdata`  in  32  value written.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  32  trace word.
- `out_last`  out  1  high on the third word of a record.
- `overflow`  out  1  sticky: set when any record has been dropped.
- `drop_count`  out  `DROP_W`  records dropped; saturates at all-ones.

## Operation
- Capture: on each rising edge with `grf_we` = 1 and `grf_addr` != 0, form a GRF record. Writes to `$0` are silently discarded and are not counted as drops. On each rising edge with `dm_we` = 1, form a DM record.
- Record fields: type (GRF = 0, DM = 1), pc[31:0], addr (GRF: zero-extended `grf_addr`; DM: `dm_addr`), data[31:0].
- Simultaneous GRF and DM events: both are pushed in the same cycle, GRF ahead of DM.
- Free space is counted before that cycle's pop; a pop in the same cycle does not make room for a push.
- Space is allocated GRF first. If one slot is free, GRF is stored and DM is dropped. If zero slots are free, both are dropped.
- Each dropped record increments `drop_count` by 1 (2 if both are dropped) and sets `overflow`.
- Serializer FSM, states `S_PC` → `S_HDR` → `S_DATA` → `S_PC`:
  - `S_PC`: `out_valid` = FIFO non-empty; `out_data` = pc.
  - `S_HDR`: `out_data` = {type, addr[30:0]}.
  - `S_DATA`: `out_data` = data; `out_last` = 1.
  - A state advances only on `out_valid && out_ready`. The record is popped on the `S_DATA` handshake.
- `out_data` and `out_last` hold stable while `out_valid && !out_ready`.

## Timing
- Reset (`reset` = 0, asynchronous): FIFO is emptied, FSM goes to `S_PC`, `out_valid` = 0, `out_data` = 0, `out_last` = 0, `overflow` = 0, `drop_count` = 0. This takes effect immediately, without waiting for a clock edge.
- Reset mid-record discards the partial record. No word is repeated or emitted after reset deassertion until a new event arrives.
- Latency: an event sampled at edge N into an empty FIFO gives `out_valid` = 1 after edge N (show-ahead FIFO, registered pointers).
- Throughput: one word per cycle with `out_ready` held high, i.e. one record per 3 cycles. Sustained dual events overflow unless the consumer keeps pace.
- Full: count == `DEPTH`. Pointers wrap modulo `DEPTH`, with an extra bit to distinguish full from empty.
- `drop_count` saturates at 2^`DROP_W`−1. `overflow` stays set until reset.

## Structure
- Package `trace_pkg`:
  - constants `TR_GRF` = 1'b0 and `TR_DM` = 1'b1;
  - record struct `trace_rec_t` {type, pc, addr, data} = 97 bits;
  - FSM state enum.
- Sub-module `trace_fifo`: dual-push (two write ports plus per-port accept outputs), single-pop, show-ahead. It owns the count and the allocation logic.
- Top level: capture/filter logic, drop accounting, and the serializer FSM.

## Test plan
- Single GRF write: pc = 0x3000, `$8` ← 0x1234, `out_ready` = 1 → words 0x00003000, 0x00000008, 0x00001234. `out_last` is high on the third word only; `out_valid` drops on the next cycle.
- Same-cycle GRF (`$3` ← 5, pc 0x3004) and DM ([0x10] ← 7, pc 0x3008) → GRF record emitted first, then words 0x00003008, 0x80000010, 0x00000007.
- `$0` write with data 0xFFFF → no output; `drop_count` stays 0.
- `out_ready` = 0 with `DEPTH` + 1 GRF writes → FIFO holds `DEPTH` records, `drop_count` = 1, `overflow` = 1. Then a same-cycle dual event → `drop_count` = 3. Release `out_ready` → exactly `DEPTH` records drain in order.
- Backpressure: toggle `out_ready` every cycle → `out_data` is stable whenever it is stalled, and no word is lost or duplicated.
- Assert `reset` = 0 asynchronously while in `S_HDR` → `out_valid` goes to 0 before the next edge, and all counters clear. After release with no events, nothing is emitted.
